// File: rtl/sr_latch_driver.sv
// Clocked front-end that turns set/reset/toggle commands into non-overlapping S/R pulses for latch_sr.
// Optional Q/QN readback checking is enabled with `define SR_READBACK_CHECK_EN.
module sr_latch_driver #(
  parameter int PULSE_W  = 4,
  parameter int SETTLE_W = 2,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       s,
  output logic       r,
  input  logic       q,
  input  logic       qn,
  output logic       done,
  output logic       err,
  output logic       state_q
);

  // state     | meaning
  // ST_INIT   | out of reset, launches the forced R pulse
  // ST_PULSE  | S or R held high, counter runs down from PULSE_W-1
  // ST_SETTLE | both drives low, latch settling
  // ST_CHECK  | Q/QN readback, DONE for user commands
  // ST_IDLE   | ready for a command
  typedef enum logic [2:0] {ST_INIT, ST_PULSE, ST_SETTLE, ST_CHECK, ST_IDLE} state_t;

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_W - 1);
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pulse_set;
  logic             skip_chk;
  logic             init_run;
  logic             accept;
  logic             accept_set;

  assign accept = cmd_valid & cmd_ready;

  // Toggle is resolved against the shadow state at the accepting edge.
  always_comb begin
    accept_set = (cmd_op == OP_SET) | ((cmd_op == OP_TOGGLE) & ~state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      state_q   <= 1'b0;
      pulse_set <= 1'b0;
      skip_chk  <= 1'b0;
      init_run  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_INIT: begin
          s         <= 1'b0;
          r         <= 1'b1;
          pulse_set <= 1'b0;
          skip_chk  <= 1'b0;
          init_run  <= 1'b1;
          cnt       <= PULSE_LD;
          state     <= ST_PULSE;
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            s       <= 1'b0;
            r       <= 1'b0;
            state_q <= pulse_set;
            cnt     <= SETTLE_LD;
            state   <= ST_SETTLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            done  <= ~init_run;
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          cmd_ready <= 1'b1;
          init_run  <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            init_run  <= 1'b0;
            if (cmd_op == OP_NOP) begin
              // NOP borrows CHECK for its DONE cycle but never compares.
              skip_chk <= 1'b1;
              done     <= 1'b1;
              state    <= ST_CHECK;
            end else begin
              skip_chk  <= 1'b0;
              pulse_set <= accept_set;
              s         <= accept_set;
              r         <= ~accept_set;
              cnt       <= PULSE_LD;
              state     <= ST_PULSE;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef SR_READBACK_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state == ST_CHECK) && !skip_chk &&
                 ((q != state_q) || (qn != ~state_q))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_readback;

  assign unused_readback = &{1'b0, q, qn, skip_chk};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a behavioural NOR latch model.
// Readback expectations follow SR_READBACK_CHECK_EN when it is defined for the build.
module tb_sr_latch_driver;

  localparam int PW = 4;

`ifdef SR_READBACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready, s, r, q, qn, done, err, state_q;
  logic       latch_q = 1'b1;
  logic       stuck = 1'b0;
  logic       err_cur = 1'b0;
  int         total = 0;
  int         bad = 0;

  sr_latch_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .s        (s),
    .r        (r),
    .q        (q),
    .qn       (qn),
    .done     (done),
    .err      (err),
    .state_q  (state_q)
  );

  always #5 clk = ~clk;

  // NOR latch: holds when both drives are low; q can be forced stuck at 0.
  always @(s or r) begin
    if (s && !r) latch_q = 1'b1;
    else if (r && !s) latch_q = 1'b0;
  end
  assign q  = stuck ? 1'b0 : latch_q;
  assign qn = ~latch_q;

  always @(negedge clk) begin
    total++;
    if ((s & r) !== 1'b0) begin
      bad++;
      $display("FAIL sr_overlap t=%0t s=%b r=%b required s&r=0", $time, s, r);
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_timeout got=%b want=1", tag, cmd_ready);
    end
  endtask

  // Called with rst_n just raised at a negedge; checks the forced R pulse.
  task automatic init_seq(input string tag);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      total++;
      if ({s, r, done, cmd_ready} !== {1'b0, (j <= PW), 1'b0, (j == 8)}) begin
        bad++;
        $display("FAIL %s cyc%0d s/r/done/ready got=%b%b%b%b want=0%b0%b",
                 tag, j, s, r, done, cmd_ready, (j <= PW), (j == 8));
      end
    end
    total++;
    if ({q, qn, state_q, err} !== 4'b0100) begin
      bad++;
      $display("FAIL %s end q/qn/state_q/err got=%b%b%b%b want=0100", tag, q, qn, state_q, err);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic exp_set, input logic err_after,
                           input string tag);
    logic pulse, exp_err;
    wait_ready(tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (j > 1) @(negedge clk);
      pulse   = (j <= PW);
      exp_err = (j == 8) ? err_after : err_cur;
      total++;
      if ({s, r, done, cmd_ready, err} !==
          {exp_set & pulse, ~exp_set & pulse, (j == 7), (j == 8), exp_err}) begin
        bad++;
        $display("FAIL %s cyc%0d s/r/done/ready/err got=%b%b%b%b%b want=%b%b%b%b%b",
                 tag, j, s, r, done, cmd_ready, err, exp_set & pulse, ~exp_set & pulse,
                 (j == 7), (j == 8), exp_err);
      end
    end
    total++;
    if ({q, qn, state_q} !== {exp_set & ~stuck, ~exp_set, exp_set}) begin
      bad++;
      $display("FAIL %s readback q/qn/state_q got=%b%b%b want=%b%b%b", tag, q, qn, state_q,
               exp_set & ~stuck, ~exp_set, exp_set);
    end
    err_cur = err_after;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({s, r, cmd_ready, done, err, state_q} !== 6'b0) begin
        bad++;
        $display("FAIL reset outputs got=%b%b%b%b%b%b want=000000", s, r, cmd_ready, done, err,
                 state_q);
      end
    end
    rst_n = 1'b1;
    init_seq("init");
  endtask

  task automatic test_set();
    issue_cmd(2'b01, 1'b1, 1'b0, "set");
  endtask

  task automatic test_toggle();
    issue_cmd(2'b11, 1'b0, 1'b0, "toggle_to_0");
    issue_cmd(2'b11, 1'b1, 1'b0, "toggle_to_1");
  endtask

  task automatic test_nop();
    wait_ready("nop");
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({s, r, done, cmd_ready} !== 4'b0010) begin
      bad++;
      $display("FAIL nop k+1 s/r/done/ready got=%b%b%b%b want=0010", s, r, done, cmd_ready);
    end
    @(negedge clk);
    total++;
    if ({s, r, done, cmd_ready, state_q} !== 5'b00011) begin
      bad++;
      $display("FAIL nop k+2 s/r/done/ready/state_q got=%b%b%b%b%b want=00011", s, r, done,
               cmd_ready, state_q);
    end
  endtask

  task automatic test_back_to_back();
    logic es, er, ed, ey;
    wait_ready("b2b");
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (j == 1) cmd_op = 2'b10;
      es = (j <= 4);
      er = (j >= 9 && j <= 12);
      ed = (j == 7 || j == 15);
      ey = (j == 8 || j >= 16);
      total++;
      if ({s, r, done, cmd_ready} !== {es, er, ed, ey}) begin
        bad++;
        $display("FAIL b2b cyc%0d s/r/done/ready got=%b%b%b%b want=%b%b%b%b", j, s, r, done,
                 cmd_ready, es, er, ed, ey);
      end
      if (j == 8 || j == 16) begin
        total++;
        if ({q, state_q} !== {2{j == 8}}) begin
          bad++;
          $display("FAIL b2b cyc%0d q/state_q got=%b%b want=%b%b", j, q, state_q, (j == 8),
                   (j == 8));
        end
      end
      if (j == 9) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_err();
    stuck = 1'b1;
    issue_cmd(2'b01, 1'b1, CHK, "err_stuck_set");
    stuck = 1'b0;
    issue_cmd(2'b10, 1'b0, CHK, "err_hold_reset");
  endtask

  task automatic test_mid_reset();
    wait_ready("mid");
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({s, r} !== 2'b10) begin
      bad++;
      $display("FAIL mid second_pulse_cycle s/r got=%b%b want=10", s, r);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({s, r, cmd_ready, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL mid cut s/r/ready/done/err got=%b%b%b%b%b want=00000", s, r, cmd_ready, done,
               err);
    end
    rst_n   = 1'b1;
    err_cur = 1'b0;
    init_seq("mid_init");
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_nop();
    test_back_to_back();
    test_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
